alu_code_scm: RTL and testbench

ALU_CODE_SCM -- requirements
Module: alu_code_scm

---
 rtl/alu_code_scm_pkg.sv | 19 +
 rtl/alu_code_scm_shifter.sv | 34 +++
 rtl/alu_code_scm.sv | 132 +++++++++++++
 tb/tb_alu_code_scm.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_code_scm_pkg.sv
// Shared opcode encoding and default data-path width for the alu_code_scm slice.
package alu_code_scm_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_SLL = 2'd2,
    OP_SLT = 2'd3
  } op_e;

  // Number of binary shift stages needed to reach a shift of exactly width,
  // so the bit shifted out by a full-width shift is still captured.
  function automatic int shift_stages(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_code_scm_shifter.sv
// Combinational logarithmic left barrel shifter with zero fill; also reports the last bit shifted out.
module alu_code_scm_shifter
  import alu_code_scm_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] amt,
  output logic [WIDTH-1:0] shifted,
  output logic             shift_out
);

  localparam int STAGES = shift_stages(WIDTH);

  // One extra guard bit on top: after a total shift of k it holds a[WIDTH-k].
  logic [WIDTH:0] stage [0:STAGES];
  logic           too_far;

  assign stage[0] = {1'b0, a};

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    assign stage[i+1] = amt[i] ? {stage[i][WIDTH-(2**i):0], {(2**i){1'b0}}} : stage[i];
  end

  if (WIDTH > STAGES) begin : g_range
    assign too_far = |amt[WIDTH-1:STAGES];
  end else begin : g_norange
    assign too_far = 1'b0;
  end

  assign shifted   = too_far ? '0   : stage[STAGES][WIDTH-1:0];
  assign shift_out = too_far ? 1'b0 : stage[STAGES][WIDTH];

endmodule

// File: rtl/alu_code_scm.sv
// Four-op ALU (ADD/SUB/SLL/SLT) with one registered result stage; ALU_CODE_SCM_FLAGS_EN adds zero/neg/carry/ovf.
// Latency 1 cycle, one op per cycle; no backpressure, out_valid pulses once per result.
module alu_code_scm
  import alu_code_scm_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic [WIDTH-1:0] o,
  output logic             out_valid
`ifdef ALU_CODE_SCM_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
`endif
);

  op_e              op;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] sll_res;
  logic [WIDTH-1:0] slt_res;
  logic [WIDTH-1:0] res_nxt;

  assign op = op_e'(s);

`ifdef ALU_CODE_SCM_FLAGS_EN
  logic add_c;
  logic sub_borrow;
  logic sll_c;
  logic carry_nxt;
  logic ovf_nxt;

  // Unsigned extension: top bit is carry for ADD and borrow (a < b) for SUB.
  assign {add_c, add_res}      = {1'b0, a} + {1'b0, b};
  assign {sub_borrow, sub_res} = {1'b0, a} - {1'b0, b};
`else
  logic sll_c_unused;

  assign add_res = a + b;
  assign sub_res = a - b;
`endif

  alu_code_scm_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .a        (a),
`ifdef ALU_CODE_SCM_FLAGS_EN
    .shift_out(sll_c),
`else
    .shift_out(sll_c_unused),
`endif
    .amt      (b),
    .shifted  (sll_res)
  );

  always_comb begin
    slt_res = '0;
    if ($signed(a) > $signed(b)) begin
      slt_res = {{(WIDTH-1){1'b0}}, 1'b1};
    end else if ($signed(a) < $signed(b)) begin
      slt_res = '1;
    end
  end

  always_comb begin
    res_nxt = add_res;
    case (op)
      OP_ADD:  res_nxt = add_res;
      OP_SUB:  res_nxt = sub_res;
      OP_SLL:  res_nxt = sll_res;
      OP_SLT:  res_nxt = slt_res;
      default: res_nxt = add_res;
    endcase
  end

`ifdef ALU_CODE_SCM_FLAGS_EN
  always_comb begin
    carry_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    case (op)
      OP_ADD: begin
        carry_nxt = add_c;
        ovf_nxt   = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        carry_nxt = sub_borrow;
        ovf_nxt   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  carry_nxt = sll_c;
      default: begin
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero  <= 1'b0;
      neg   <= 1'b0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (in_valid) begin
      zero  <= (res_nxt == '0);
      neg   <= res_nxt[WIDTH-1];
      carry <= carry_nxt;
      ovf   <= ovf_nxt;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        o <= res_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_code_scm.sv
// Scoreboard bench for alu_code_scm: directed sweeps, mid-stream reset and randomized traffic vs. an integer model.
module tb_alu_code_scm;
  import alu_code_scm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [1:0]  s = '0;
  logic        in_valid = 1'b0;
  logic [15:0] o;
  logic        out_valid;
`ifdef ALU_CODE_SCM_FLAGS_EN
  logic zero, neg, carry, ovf;
`endif

  alu_code_scm #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .s        (s),
    .in_valid (in_valid),
    .o        (o),
    .out_valid(out_valid)
`ifdef ALU_CODE_SCM_FLAGS_EN
    ,
    .zero     (zero),
    .neg      (neg),
    .carry    (carry),
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int res;
    int zero;
    int neg;
    int carry;
    int ovf;
    int due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules, using plain integers.
  function automatic exp_t model(input int av, input int bv, input int op);
    exp_t e;
    int   sa, sb, r, sr;
    sa = (av >= 32768) ? av - 65536 : av;
    sb = (bv >= 32768) ? bv - 65536 : bv;
    e.carry = 0;
    e.ovf   = 0;
    r       = 0;
    case (op)
      0: begin
        r       = av + bv;
        e.carry = (r > 65535) ? 1 : 0;
        sr      = sa + sb;
        e.ovf   = (sr > 32767 || sr < -32768) ? 1 : 0;
      end
      1: begin
        r       = av - bv;
        e.carry = (av < bv) ? 1 : 0;
        sr      = sa - sb;
        e.ovf   = (sr > 32767 || sr < -32768) ? 1 : 0;
      end
      2: begin
        r       = (bv >= 16) ? 0 : (av << bv);
        e.carry = (bv >= 1 && bv <= 16) ? ((av >> (16 - bv)) & 1) : 0;
      end
      default: r = (sa > sb) ? 1 : ((sa == sb) ? 0 : 65535);
    endcase
    e.res  = r & 65535;
    e.zero = (e.res == 0) ? 1 : 0;
    e.neg  = (e.res >= 32768) ? 1 : 0;
    e.due  = 0;
    return e;
  endfunction

  task automatic drive(input int av, input int bv, input int op);
    exp_t e;
    a        = 16'(av);
    b        = 16'(bv);
    s        = 2'(op);
    in_valid = 1'b1;
    e        = model(av, bv, op);
    e.due    = cyc + 1;
    q.push_back(e);
  endtask

  task automatic issue(input int av, input int bv, input int op);
    @(negedge clk);
    drive(av, bv, op);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      s        = 2'($urandom);
    end
  endtask

  // Monitor: pops the oldest expectation whenever a result is presented.
  int   last_o = 0;
  exp_t m;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_o = 0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        m = q.pop_front();
        check("result", int'(o), m.res);
        check("latency", cyc, m.due);
`ifdef ALU_CODE_SCM_FLAGS_EN
        check("zero", int'(zero), m.zero);
        check("neg", int'(neg), m.neg);
        check("carry", int'(carry), m.carry);
        check("ovf", int'(ovf), m.ovf);
`endif
      end
      last_o = int'(o);
    end else begin
      check("hold_o", int'(o), last_o);
      if (q.size() > 0 && q[0].due <= cyc) begin
        check("missing_out_valid", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #1;
    check("reset_o", int'(o), 0);
    check("reset_out_valid", int'(out_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(5, 9, 0);

    for (int i = 2; i <= 6; i++) issue(i, 1, 0);
    issue(16'hFFFF, 1, 0);
    for (int i = 7; i <= 11; i++) issue(i, 1, 1);
    issue(0, 1, 1);
    for (int i = 12; i <= 16; i++) issue(i, 2, 2);
    issue(1, 16, 2);
    issue(2, 1, 3);
    issue(2, 2, 3);
    issue(2, 3, 3);
    issue(16'h8000, 1, 3);
    idle(2);

    // Asynchronous reset between edges, with an operation still being presented.
    issue(16'h1234, 16'h0101, 0);
    issue(16'h4321, 3, 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_o", int'(o), 0);
    check("midreset_out_valid", int'(out_valid), 0);
`ifdef ALU_CODE_SCM_FLAGS_EN
    check("midreset_flags", int'({zero, neg, carry, ovf}), 0);
`endif
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(3);
    check("post_reset_o", int'(o), 0);
    check("post_reset_out_valid", int'(out_valid), 0);

    for (int n = 0; n < 400; n++) begin
      int av, bv, op;
      op = int'($urandom_range(0, 3));
      av = int'($urandom_range(0, 65535));
      case ($urandom_range(0, 3))
        0:       bv = int'($urandom_range(0, 20));
        1:       bv = av;
        default: bv = int'($urandom_range(0, 65535));
      endcase
      if ($urandom_range(0, 9) < 3) idle(1);
      issue(av, bv, op);
    end

    idle(1);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) check("drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
